// File: rtl/cdc_pkg.sv
// Shared definitions for the toggle req/ack clock-domain crossing (transmitter and receiver).
package cdc_pkg;

    typedef enum logic {TX_IDLE, TX_WAIT_ACK} cdc_tx_state_t;

    localparam int ACK_SYNC_STAGES = 3;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_ff_n.sv
// Multi-stage flop-chain synchronizer with asynchronous active-low reset to zero.
module sync_ff_n #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < STAGES; i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Source-domain transmitter of a two-phase toggle req/ack crossing with a small input queue.
module cdc_handshake_tx
    import cdc_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int FIFO_DEPTH     = 2,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [WIDTH-1:0]  data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic [WIDTH-1:0]  data_o,
    output logic              req_o,
    input  logic              ack_toggle_i,
    output logic              busy_o,
    output logic              error_o,
    output cdc_tx_state_t     dbg_state
);

    // Handshake: a word is pushed on any edge where valid_i and ready_o are both
    // high; ready_o depends only on the queue fill level, never on valid_i.

    localparam int PTR_W = cnt_width(FIFO_DEPTH);
    localparam int CNT_W = cnt_width(FIFO_DEPTH + 1);
    localparam int TMO_W = cnt_width(TIMEOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_MAX   = '1;

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic             ack_s;
    cdc_tx_state_t    state;
    cdc_tx_state_t    state_nxt;
    logic             push;
    logic             pop;
    logic             load;
    logic             tmo_inc;
    logic             tmo_hit;
    logic             fifo_empty;
    logic             ack_done;
    logic [TMO_W-1:0] tmo_cnt;
    logic [TMO_W-1:0] tmo_next;

    sync_ff_n #(
        .WIDTH  (1),
        .STAGES (ACK_SYNC_STAGES)
    ) u_ack_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (ack_toggle_i),
        .q       (ack_s)
    );

    assign ready_o    = (count != DEPTH_C);
    assign push       = valid_i & ready_o;
    assign fifo_empty = (count == '0);
    assign ack_done   = (ack_s == req_o);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= TX_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The head entry stays queued until acknowledged; it is popped only on completion.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        pop       = 1'b0;
        tmo_inc   = 1'b0;
        case (state)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    load      = 1'b1;
                    state_nxt = TX_WAIT_ACK;
                end
            end
            TX_WAIT_ACK: begin
                if (ack_done) begin
                    pop       = 1'b1;
                    state_nxt = TX_IDLE;
                end else begin
                    tmo_inc = 1'b1;
                end
            end
            default: state_nxt = TX_IDLE;
        endcase
    end

    assign tmo_next = (tmo_cnt == TMO_MAX) ? tmo_cnt : tmo_cnt + TMO_W'(1);
    assign tmo_hit  = (TIMEOUT_CYCLES != 0) && tmo_inc && (tmo_next == TMO_LIMIT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_o  <= '0;
            req_o   <= 1'b0;
            tmo_cnt <= '0;
            error_o <= 1'b0;
        end else begin
            if (load) begin
                data_o  <= mem[rd_ptr];
                req_o   <= ~req_o;
                tmo_cnt <= '0;
            end else if (tmo_inc) begin
                tmo_cnt <= tmo_next;
            end
            if (tmo_hit) begin
                error_o <= 1'b1;
            end
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_i;
        end
    end

    assign busy_o    = (state == TX_WAIT_ACK);
    assign dbg_state = state;

endmodule
